llr_frame_packer: RTL and testbench

Downstream of `ml_demodulator`: collects the serial `(o_llr, o_hard_bit)` stream, eight symbols-bits per 4x4 MIMO frame, via its valid/ready handshake. Packs each group of eight into one 64-bit LLR word plus an 8-bit hard-decision byte. Buffers up to `DEPTH` complete frames and presents them to the channel-decoder interface with its own valid/ready handshake. Checks every frame for LLR/hard-bit consistency.

---
 rtl/ml_pkg.sv | 20 ++
 rtl/frm_fifo.sv | 59 +++++
 rtl/llr_frame_packer.sv | 98 +++++++++
 tb/tb_llr_frame_packer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ml_pkg.sv
// Shared types for the LLR frame packer: LLR geometry, the packed frame record
// and the per-LLR consistency check.
package ml_pkg;

  localparam int LLR_W = 8;
  localparam int N_LLR = 8;
  localparam int IDX_W = $clog2(N_LLR);

  typedef struct packed {
    logic                   err;
    logic [N_LLR-1:0]       hb;
    logic [N_LLR*LLR_W-1:0] llr;
  } frm_t;

  // An LLR of zero carries no decision; otherwise its sign must agree with the hard bit.
  function automatic logic llr_err(input logic [LLR_W-1:0] llr, input logic hb);
    return (llr == {LLR_W{1'b0}}) | (llr[LLR_W-1] != hb);
  endfunction

endpackage

// File: rtl/frm_fifo.sv
// Register-array FIFO of packed frames with asynchronous read at the read pointer.
// Push is ignored when full and pop when empty.
module frm_fifo
  import ml_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_push,
  input  frm_t i_data,
  input  logic i_pop,
  output frm_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  frm_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == {CW{1'b0}});
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {$bits(frm_t){1'b0}};
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/llr_frame_packer.sv
// Collects N_LLR serial (LLR, hard bit) pairs into one frame, flags inconsistent
// frames, and buffers complete frames for the channel decoder.
module llr_frame_packer
  import ml_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_llr_vld,
  output logic                   o_llr_rdy,
  input  logic [LLR_W-1:0]       i_llr,
  input  logic                   i_hard_bit,
  output logic                   o_frm_vld,
  input  logic                   i_frm_rdy,
  output logic [LLR_W*N_LLR-1:0] o_frm_llr,
  output logic [N_LLR-1:0]       o_frm_hb,
  output logic                   o_frm_err,
  output logic                   o_err_sticky
);

  logic [N_LLR*LLR_W-1:0] r_llr;
  logic [N_LLR-1:0]       r_hb;
  logic                   r_err;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_sticky;

  logic                   w_xfer;
  logic                   w_last;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  frm_t                   w_frm;
  frm_t                   w_head;

  // Readiness comes from registered state only: only the closing slot waits for room.
  assign w_last    = (r_idx == IDX_W'(N_LLR - 1));
  assign o_llr_rdy = ~w_last | ~w_full;
  assign w_xfer    = i_llr_vld & o_llr_rdy;
  assign o_frm_vld = ~w_empty;
  assign w_pop     = o_frm_vld & i_frm_rdy;

  // Frame as it stands once the current LLR is merged into slot r_idx.
  always_comb begin
    w_frm = {$bits(frm_t){1'b0}};
    for (int k = 0; k < N_LLR; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_frm.llr[k*LLR_W +: LLR_W] = i_llr;
        w_frm.hb[k]                 = i_hard_bit;
      end else begin
        w_frm.llr[k*LLR_W +: LLR_W] = r_llr[k*LLR_W +: LLR_W];
        w_frm.hb[k]                 = r_hb[k];
      end
    end
    w_frm.err = r_err | llr_err(i_llr, i_hard_bit);
  end

  // Assembly register, slot index and sticky error flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_llr    <= {(N_LLR*LLR_W){1'b0}};
      r_hb     <= {N_LLR{1'b0}};
      r_err    <= 1'b0;
      r_idx    <= {IDX_W{1'b0}};
      r_sticky <= 1'b0;
    end else if (w_xfer) begin
      r_llr <= w_frm.llr;
      r_hb  <= w_frm.hb;
      if (w_last) begin
        r_idx    <= {IDX_W{1'b0}};
        r_err    <= 1'b0;
        r_sticky <= r_sticky | w_frm.err;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
        r_err <= w_frm.err;
      end
    end
  end

  frm_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_push   (w_xfer & w_last),
    .i_data   (w_frm),
    .i_pop    (w_pop),
    .o_data   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign o_frm_llr    = w_head.llr;
  assign o_frm_hb     = w_head.hb;
  assign o_frm_err    = w_head.err;
  assign o_err_sticky = r_sticky;

endmodule

// File: tb/tb_llr_frame_packer.sv
// Self-checking bench for llr_frame_packer: directed scenarios with random LLR
// payloads, compared each cycle against a queue-based frame model.
module tb_llr_frame_packer;

  localparam int DEPTH = 4;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_llr_vld;
  logic        o_llr_rdy;
  logic [7:0]  i_llr;
  logic        i_hard_bit;
  logic        o_frm_vld;
  logic        i_frm_rdy;
  logic [63:0] o_frm_llr;
  logic [7:0]  o_frm_hb;
  logic        o_frm_err;
  logic        o_err_sticky;

  llr_frame_packer #(.DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_llr_vld   (i_llr_vld),
    .o_llr_rdy   (o_llr_rdy),
    .i_llr       (i_llr),
    .i_hard_bit  (i_hard_bit),
    .o_frm_vld   (o_frm_vld),
    .i_frm_rdy   (i_frm_rdy),
    .o_frm_llr   (o_frm_llr),
    .o_frm_hb    (o_frm_hb),
    .o_frm_err   (o_frm_err),
    .o_err_sticky(o_err_sticky)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] llr;
    logic [7:0]  hb;
    logic        err;
  } mfrm_t;

  int    errors = 0;
  int    checks = 0;
  mfrm_t ref_q[$];
  logic [7:0] a_llr[8];
  logic       a_hb[8];
  int    a_n = 0;
  logic  m_sticky = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic mfrm_t build_frame();
    mfrm_t f;
    f.llr = 64'h0;
    f.hb  = 8'h0;
    f.err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      f.llr = f.llr | (64'(a_llr[k]) << (8 * k));
      f.hb[k] = a_hb[k];
      if (a_llr[k] == 8'h00 || (($signed(a_llr[k]) < 0) != a_hb[k])) f.err = 1'b1;
    end
    return f;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic vld, input logic [7:0] llr, input logic hb,
                       input logic frdy, output logic xfer);
    logic m_rdy;
    logic pop;
    i_llr_vld  = vld;
    i_llr      = llr;
    i_hard_bit = hb;
    i_frm_rdy  = frdy;
    #1;
    m_rdy = (a_n != 7) || (ref_q.size() != DEPTH);
    chk("llr_rdy", 64'(o_llr_rdy), 64'(m_rdy));
    chk("frm_vld", 64'(o_frm_vld), 64'(ref_q.size() != 0));
    chk("err_sticky", 64'(o_err_sticky), 64'(m_sticky));
    if (ref_q.size() != 0) begin
      chk("frm_llr", o_frm_llr, ref_q[0].llr);
      chk("frm_hb", 64'(o_frm_hb), 64'(ref_q[0].hb));
      chk("frm_err", 64'(o_frm_err), 64'(ref_q[0].err));
    end
    xfer = vld && m_rdy;
    pop  = (ref_q.size() != 0) && frdy;
    @(posedge i_clk);
    if (pop) void'(ref_q.pop_front());
    if (xfer) begin
      a_llr[a_n] = llr;
      a_hb[a_n]  = hb;
      a_n++;
      if (a_n == 8) begin
        mfrm_t f;
        f = build_frame();
        ref_q.push_back(f);
        if (f.err) m_sticky = 1'b1;
        a_n = 0;
      end
    end
    #1;
  endtask

  task automatic send(input logic [7:0] llr, input logic hb, input logic frdy);
    logic x;
    x = 1'b0;
    for (int t = 0; t < 64 && !x; t++) cycle(1'b1, llr, hb, frdy, x);
    if (!x) chk("send_timeout", 64'(x), 64'(1));
  endtask

  task automatic send_good(input logic frdy);
    logic [7:0] v;
    v = 8'($urandom_range(255, 1));
    send(v, v[7], frdy);
  endtask

  task automatic idle(input logic frdy, input int n);
    logic x;
    for (int t = 0; t < n; t++) cycle(1'b0, 8'h00, 1'b0, frdy, x);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rdy"}, 64'(o_llr_rdy), 64'(1));
    chk({tag, "_vld"}, 64'(o_frm_vld), 64'(0));
    chk({tag, "_llr"}, o_frm_llr, 64'h0);
    chk({tag, "_hb"}, 64'(o_frm_hb), 64'h0);
    chk({tag, "_err"}, 64'(o_frm_err), 64'(0));
    chk({tag, "_sticky"}, 64'(o_err_sticky), 64'(0));
  endtask

  task automatic model_reset();
    ref_q.delete();
    a_n      = 0;
    m_sticky = 1'b0;
  endtask

  logic [7:0] tp_llr[8];
  logic [7:0] bp_llr;
  logic       x;

  initial begin
    tp_llr = '{8'h10, 8'h90, 8'h20, 8'hA0, 8'h30, 8'hB0, 8'h40, 8'hC0};
    i_reset_n = 1'b0; i_llr_vld = 1'b0; i_llr = 8'h00; i_hard_bit = 1'b0; i_frm_rdy = 1'b0;
    #3;
    reset_checks("rst");
    @(posedge i_clk);
    #3 i_reset_n = 1'b1;
    model_reset();

    // Directed frame from the test plan.
    for (int k = 0; k < 8; k++) send(tp_llr[k], k[0], 1'b1);
    chk("tp_llr", o_frm_llr, 64'hC040B030A0209010);
    chk("tp_hb", 64'(o_frm_hb), 64'hAA);
    chk("tp_err", 64'(o_frm_err), 64'(0));
    chk("tp_vld", 64'(o_frm_vld), 64'(1));
    idle(1'b1, 2);

    // Backpressure: four frames fill the FIFO, slot 7 of frame five stalls.
    for (int k = 0; k < 39; k++) send_good(1'b0);
    bp_llr = 8'($urandom_range(255, 1));
    for (int t = 0; t < 3; t++) cycle(1'b1, bp_llr, bp_llr[7], 1'b0, x);
    chk("bp_stall", 64'(o_llr_rdy), 64'(0));
    cycle(1'b1, bp_llr, bp_llr[7], 1'b1, x);
    chk("bp_first_pop_no_xfer", 64'(x), 64'(0));
    chk("bp_rdy_after_pop", 64'(o_llr_rdy), 64'(1));
    send(bp_llr, bp_llr[7], 1'b1);
    idle(1'b1, 6);

    // Error detection: zero LLR in frame two only.
    for (int k = 0; k < 8; k++) send_good(1'b1);
    chk("sticky_before", 64'(o_err_sticky), 64'(0));
    for (int k = 0; k < 8; k++) begin
      if (k == 3) send(8'h00, 1'($urandom_range(1, 0)), 1'b1);
      else send_good(1'b1);
    end
    chk("zero_err", 64'(o_frm_err), 64'(1));
    chk("sticky_after", 64'(o_err_sticky), 64'(1));
    for (int k = 0; k < 8; k++) send_good(1'b1);
    idle(1'b1, 3);

    // Positive LLR with hard bit 1 is a sign mismatch.
    for (int k = 0; k < 8; k++) begin
      if (k == 5) send(8'h7F, 1'b1, 1'b1);
      else send_good(1'b1);
    end
    chk("sign_err", 64'(o_frm_err), 64'(1));
    idle(1'b1, 3);

    // Steady state at two buffered frames: each push coincides with one pop.
    for (int k = 0; k < 16; k++) send_good(1'b0);
    for (int f = 0; f < 64; f++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(3, 0) == 0) idle(1'b0, 1);
        if ($urandom_range(15, 0) == 0) send(8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), k == 7);
        else send_good(k == 7);
      end
    end
    idle(1'b1, 3);

    // Asynchronous reset with two frames buffered and a partial frame pending.
    for (int k = 0; k < 19; k++) send_good(1'b0);
    chk("pre_rst_vld", 64'(o_frm_vld), 64'(1));
    i_reset_n = 1'b0;
    i_llr_vld = 1'b0;
    #1;
    reset_checks("async_rst");
    @(posedge i_clk);
    #3 i_reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 8; k++) send_good(1'b0);
    chk("post_rst_one_frame", 64'(o_frm_vld), 64'(1));
    idle(1'b1, 1);
    idle(1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
